// File: rtl/branch_predict_unit.sv
// Per-PC 2-bit saturating-counter branch predictor with zero-latency flush/redirect.
// Optional resolve/mispredict statistics counters are enabled by defining BPU_STATS_EN.
module branch_predict_unit #(
  parameter int unsigned ENTRIES    = 16,
  parameter logic [1:0]  INIT_STATE = 2'b11
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lookup_valid_i,
  input  logic [31:0] lookup_pc_i,
  output logic        predict_o,
  input  logic        resolve_valid_i,
  input  logic [31:0] resolve_pc_i,
  input  logic        resolve_taken_i,
  input  logic        resolve_pred_i,
  output logic        flush_o,
  output logic        redirect_taken_o
`ifdef BPU_STATS_EN
  ,
  output logic [31:0] branch_cnt_o,
  output logic [31:0] mispredict_cnt_o
`endif
);

  localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  ctr_e             table_q [ENTRIES];
  ctr_e             cnt_q;
  ctr_e             cnt_d;
  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] resolve_idx;
  logic             unused_pc_bits;

  // Word-aligned PCs: bits [1:0] never vary, upper bits alias (no tag).
  assign lookup_idx     = lookup_pc_i[IDX_W+1:2];
  assign resolve_idx    = resolve_pc_i[IDX_W+1:2];
  assign unused_pc_bits = ^{lookup_pc_i[31:IDX_W+2], lookup_pc_i[1:0],
                            resolve_pc_i[31:IDX_W+2], resolve_pc_i[1:0]};

  assign flush_o          = ~rst_i & resolve_valid_i & (resolve_taken_i ^ resolve_pred_i);
  assign predict_o        = ~rst_i & lookup_valid_i & table_q[lookup_idx][1] & ~flush_o;
  assign redirect_taken_o = resolve_taken_i;

  assign cnt_q = table_q[resolve_idx];

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (resolve_taken_i) begin
      if (cnt_q != ST) cnt_d = ctr_e'(cnt_q + 2'd1);
    end else begin
      if (cnt_q != SNT) cnt_d = ctr_e'(cnt_q - 2'd1);
    end
  end

  // NOTE: the table is small flop storage, so a full synchronous reset is intended here;
  // a large RAM-backed table would need an init sequencer instead.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(ENTRIES); i++) table_q[i] <= ctr_e'(INIT_STATE);
    end else if (resolve_valid_i) begin
      table_q[resolve_idx] <= cnt_d;
    end
  end

`ifdef BPU_STATS_EN
  logic [31:0] branch_cnt_q;
  logic [31:0] mispredict_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      if (resolve_valid_i) branch_cnt_q     <= branch_cnt_q + 32'd1;
      if (flush_o)         mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
    end
  end

  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed, table-driven bench for branch_predict_unit (ENTRIES=16, INIT_STATE=11),
// with hand-written reset and statistics sequences.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        predict;
  logic        resolve_valid;
  logic [31:0] resolve_pc;
  logic        resolve_taken;
  logic        resolve_pred;
  logic        flush;
  logic        redirect_taken;
`ifdef BPU_STATS_EN
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_predict_unit #(.ENTRIES(16), .INIT_STATE(2'b11)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .lookup_valid_i   (lookup_valid),
    .lookup_pc_i      (lookup_pc),
    .predict_o        (predict),
    .resolve_valid_i  (resolve_valid),
    .resolve_pc_i     (resolve_pc),
    .resolve_taken_i  (resolve_taken),
    .resolve_pred_i   (resolve_pred),
    .flush_o          (flush),
    .redirect_taken_o (redirect_taken)
`ifdef BPU_STATS_EN
    ,
    .branch_cnt_o     (branch_cnt),
    .mispredict_cnt_o (mispredict_cnt)
`endif
  );

  typedef struct {
    string       name;
    logic        lv;
    logic [31:0] lpc;
    logic        rv;
    logic [31:0] rpc;
    logic        rt;
    logic        rp;
    logic        exp_pred;
    logic        exp_flush;
    logic        exp_redir;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later, well away from posedge.
  task automatic drive(input logic r, input logic lv, input logic [31:0] lpc, input logic rv,
                       input logic [31:0] rpc, input logic rt, input logic rp);
    @(negedge clk);
    rst = r; lookup_valid = lv; lookup_pc = lpc;
    resolve_valid = rv; resolve_pc = rpc; resolve_taken = rt; resolve_pred = rp;
    #1;
  endtask

  function automatic vec_t mk(input string n, input logic lv, input logic [31:0] lpc,
                              input logic rv, input logic [31:0] rpc, input logic rt,
                              input logic rp, input logic ep, input logic ef, input logic er);
    vec_t v;
    v.name = n; v.lv = lv; v.lpc = lpc; v.rv = rv; v.rpc = rpc; v.rt = rt; v.rp = rp;
    v.exp_pred = ep; v.exp_flush = ef; v.exp_redir = er;
    return v;
  endfunction

  initial begin
    // Counter state of index 4 (pc 0x10/0x50) noted after each row's edge.
    vecs[0]  = mk("init_lookup_10",   1, 32'h10, 0, 32'h0,  0, 0, 1, 0, 0); // 11
    vecs[1]  = mk("nt1_mispredict",   0, 32'h0,  1, 32'h10, 0, 1, 0, 1, 0); // 10
    vecs[2]  = mk("nt2_masked",       1, 32'h10, 1, 32'h10, 0, 1, 0, 1, 0); // 01
    vecs[3]  = mk("nt3_correct",      1, 32'h10, 1, 32'h10, 0, 0, 0, 0, 0); // 00
    vecs[4]  = mk("nt4_saturate",     1, 32'h10, 1, 32'h10, 0, 0, 0, 0, 0); // 00
    vecs[5]  = mk("lookup_10_snt",    1, 32'h10, 0, 32'h0,  0, 0, 0, 0, 0);
    vecs[6]  = mk("indep_14",         1, 32'h14, 0, 32'h0,  0, 0, 1, 0, 0);
    vecs[7]  = mk("alias_50",         1, 32'h50, 0, 32'h0,  0, 0, 0, 0, 0);
    vecs[8]  = mk("t1_flush_masks",   1, 32'h14, 1, 32'h10, 1, 0, 0, 1, 1); // 01
    vecs[9]  = mk("hyst_wnt",         1, 32'h10, 0, 32'h0,  0, 0, 0, 0, 0);
    vecs[10] = mk("t2_mispredict",    0, 32'h0,  1, 32'h10, 1, 0, 0, 1, 1); // 10
    vecs[11] = mk("hyst_wt",          1, 32'h10, 0, 32'h0,  0, 0, 1, 0, 0);
    vecs[12] = mk("same_idx_cycle",   1, 32'h10, 1, 32'h10, 0, 1, 0, 1, 0); // 01
    vecs[13] = mk("same_idx_next",    1, 32'h10, 0, 32'h0,  0, 0, 0, 0, 0);
    vecs[14] = mk("correct_t_via50",  1, 32'h50, 1, 32'h10, 1, 1, 0, 0, 1); // 10
    vecs[15] = mk("lookup_50_wt",     1, 32'h50, 0, 32'h0,  0, 0, 1, 0, 0);
    vecs[16] = mk("rv0_no_flush",     1, 32'h10, 0, 32'h10, 1, 0, 1, 0, 1); // 10 unchanged
    vecs[17] = mk("rv0_no_update",    1, 32'h10, 0, 32'h0,  0, 0, 1, 0, 0);

    rst = 1'b1; lookup_valid = 1'b0; lookup_pc = '0;
    resolve_valid = 1'b0; resolve_pc = '0; resolve_taken = 1'b0; resolve_pred = 1'b0;

    // Reset cycle: outputs gated even with a mispredicting resolve present.
    drive(1, 1, 32'h10, 1, 32'h10, 0, 1);
    check("rst_predict", {31'b0, predict}, 32'd0);
    check("rst_flush",   {31'b0, flush},   32'd0);
    drive(0, 0, 32'h0, 0, 32'h0, 0, 0);
    check("post_rst_predict", {31'b0, predict},        32'd0);
    check("post_rst_flush",   {31'b0, flush},          32'd0);
    check("post_rst_redir",   {31'b0, redirect_taken}, 32'd0);

    foreach (vecs[i]) begin
      drive(0, vecs[i].lv, vecs[i].lpc, vecs[i].rv, vecs[i].rpc, vecs[i].rt, vecs[i].rp);
      check({vecs[i].name, ".predict"}, {31'b0, predict},        {31'b0, vecs[i].exp_pred});
      check({vecs[i].name, ".flush"},   {31'b0, flush},          {31'b0, vecs[i].exp_flush});
      check({vecs[i].name, ".redir"},   {31'b0, redirect_taken}, {31'b0, vecs[i].exp_redir});
    end

    // Drive 0x14 down to 01 so the mid-run reset has something to restore.
    drive(0, 0, 32'h0, 1, 32'h14, 0, 1);
    drive(0, 0, 32'h0, 1, 32'h14, 0, 1);
    drive(0, 1, 32'h14, 0, 32'h0, 0, 0);
    check("pre_rst_14_wnt", {31'b0, predict}, 32'd0);

    // Mid-run reset with an in-flight resolve that must be discarded.
    drive(1, 1, 32'h14, 1, 32'h14, 0, 1);
    check("midrst_predict", {31'b0, predict}, 32'd0);
    check("midrst_flush",   {31'b0, flush},   32'd0);
    drive(0, 1, 32'h14, 0, 32'h0, 0, 0);
    check("midrst_14_restored", {31'b0, predict}, 32'd1);
    drive(0, 1, 32'h10, 0, 32'h0, 0, 0);
    check("midrst_10_restored", {31'b0, predict}, 32'd1);
`ifdef BPU_STATS_EN
    check("midrst_branch_cnt",     branch_cnt,     32'd0);
    check("midrst_mispredict_cnt", mispredict_cnt, 32'd0);

    // Five resolves, two of them mispredicted.
    drive(0, 0, 32'h0, 1, 32'h20, 1, 1);
    drive(0, 0, 32'h0, 1, 32'h20, 0, 1);
    drive(0, 0, 32'h0, 1, 32'h20, 1, 1);
    drive(0, 0, 32'h0, 1, 32'h20, 0, 0);
    drive(0, 0, 32'h0, 1, 32'h20, 1, 0);
    drive(0, 0, 32'h0, 0, 32'h0, 0, 0);
    check("stats_branch_cnt",     branch_cnt,     32'd5);
    check("stats_mispredict_cnt", mispredict_cnt, 32'd2);

    drive(1, 0, 32'h0, 1, 32'h20, 0, 1);
    drive(0, 1, 32'h20, 0, 32'h0, 0, 0);
    check("stats_rst_branch_cnt",     branch_cnt,     32'd0);
    check("stats_rst_mispredict_cnt", mispredict_cnt, 32'd0);
    check("stats_rst_20_restored",    {31'b0, predict}, 32'd1);
`endif

    drive(0, 0, 32'h0, 0, 32'h0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
